mul_share_sched: RTL
====================

Name: mul_share_sched

Overview:
- Round-robin scheduler that shares one pipelined Multiplier_booth instance among NUM_REQ requesters.
- Each requester has a valid/ready operand port. Products return on a single valid/ready result port, tagged with the requester id.
- Owns the multiplier's operand registers and pip_en. Freezes the whole pipeline, including its own tag pipe, under result backpressure.
- Sits between the PE operand fetch logic and the shared multiplier in the systolic datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ), derived localparam, min 1.
- WIDTH_A, 16, operand A width.
- WIDTH_B, 16, operand B width.
- WIDTH_MUL, 32, product width (WIDTH_A+WIDTH_B).
- MUL_LAT, 2, pip_en-gated register stages inside the multiplier from A/B to OUT (0 = combinational).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*WIDTH_A  flattened operand A; requester i at [i*WIDTH_A +: WIDTH_A].
- req_b  in  NUM_REQ*WIDTH_B  flattened operand B, same packing.
- mul_a  out  WIDTH_A  to multiplier A (registered).
- mul_b  out  WIDTH_B  to multiplier B (registered).
- mul_pip_en  out  1  to multiplier pip_en.
- mul_out  in  WIDTH_MUL  from multiplier OUT.
- res_valid  out  1  result valid.
- res_ready  in  1  result accept.
- res_data  out  WIDTH_MUL  product.
- res_id  out  ID_W  requester index of the product.
- busy  out  1  any operation in flight or result held.
- issue_cnt  out  16  accepted-operation counter, wraps at 2^16.

Behaviour:
- Top level ties the multiplier reset as rst_n = ~rst. Both resets assert together.
- Reset values: res_valid 0, res_data 0, res_id 0, mul_a 0, mul_b 0, all tag valids 0, rr_ptr 0, issue_cnt 0.
- While rst is high, req_ready = 0 and busy = 0.
- Advance signal: adv = !res_valid || res_ready. mul_pip_en = adv, combinational.
- Grant: round-robin over req_valid, searching from rr_ptr upward with modulo wrap. Grant is combinational.
  - req_ready[i] = adv && grant[i].
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
- Handshake on port i occurs when req_valid[i] && req_ready[i] at a rising edge. At that edge:
  - {mul_a, mul_b} load the port i operands.
  - tag[0] loads {v=1, id=i}.
  - rr_ptr becomes (i+1) mod NUM_REQ.
  - issue_cnt increments.
- adv high with no handshake: tag[0].v loads 0; mul_a/mul_b hold.
- adv low: mul_a, mul_b, all tags, the result register and rr_ptr hold. The multiplier freezes via pip_en.
- Tag pipe: tag[0..MUL_LAT], shifting tag[k] <= tag[k-1] on adv. mul_out is aligned with tag[MUL_LAT].
- Result register, on adv: res_valid <= tag[MUL_LAT].v. If that tag is valid, res_data <= mul_out and res_id <= tag[MUL_LAT].id; otherwise res_data and res_id hold.
- Latency: handshake at edge E, no stall → res_valid high from edge E+MUL_LAT+1. Each stall cycle adds one cycle.
- Throughput: one op per cycle sustained while res_ready = 1.
- res_valid, res_data and res_id hold stable while res_valid && !res_ready.
- A result dequeue and a new issue in the same cycle are both allowed (adv = 1 via res_ready).
- Ordering: results leave in issue order, with no reordering between ids.
- No valid requester: rr_ptr holds and the pipeline drains normally.
- busy = res_valid || OR(tag[k].v).
- Reset mid-operation discards all in-flight ops. No result is emitted for them, and rr_ptr returns to 0.
- Arithmetic and signedness are owned by the multiplier (SIGNED parameter). The scheduler passes operands unmodified.

Test Plan:
- Single op: MUL_LAT=2, port 1 sends A=0x7FFF, B=0x7FFF, res_ready=1 → res_valid at handshake+3 cycles, res_data=0x3FFF0001, res_id=1, issue_cnt=1.
- All four ports valid from reset, all held valid, res_ready=1:
  - Grants 0,1,2,3 on consecutive cycles.
  - Results in the same order, one per cycle.
  - Port 0 A=0x8000, B=0x8000 → 0x40000000. Port 2 A=0xFFFF, B=0x0001 → 0xFFFFFFFF (signed).
- Backpressure: 3 ops issued, res_ready held 0 for 5 cycles →
  - First result held stable.
  - mul_pip_en=0 and req_ready=0 throughout the stall.
  - After release, the remaining 2 results arrive on consecutive cycles, none lost.
- Round-robin wrap: rr_ptr=3, ports 0 and 3 valid → port 3 granted, then port 0. Port 3 alone repeatedly → granted every cycle.
- Reset mid-flight: 2 ops in tag pipe, assert rst for 1 cycle → res_valid never rises for them, busy=0, next grant starts at port 0.
- issue_cnt wrap: preload via 65536 back-to-back ops → counter returns to 0.

Source files
------------

// File: rtl/mul_share_sched.sv
// Round-robin scheduler sharing one pipelined multiplier among NUM_REQ requesters.
// A tag pipe tracks requester ids alongside the multiplier stages; result backpressure freezes everything.
`timescale 1ns/1ps
module mul_share_sched #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH_A   = 16,
    parameter int unsigned WIDTH_B   = 16,
    parameter int unsigned WIDTH_MUL = 32,
    parameter int unsigned MUL_LAT   = 2,
    localparam int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*WIDTH_A-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH_B-1:0]   req_b,
    output logic [WIDTH_A-1:0]           mul_a,
    output logic [WIDTH_B-1:0]           mul_b,
    output logic                         mul_pip_en,
    input  logic [WIDTH_MUL-1:0]         mul_out,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [WIDTH_MUL-1:0]         res_data,
    output logic [ID_W-1:0]              res_id,
    output logic                         busy,
    output logic [15:0]                  issue_cnt
);

    localparam int unsigned SUM_W = ID_W + 1;

    logic                          adv;
    logic                          hs;
    logic                          grant_vld;
    logic [ID_W-1:0]               grant_id;
    logic [SUM_W-1:0]              cand_sum;

    logic [WIDTH_A-1:0]            mul_a_q, mul_a_d;
    logic [WIDTH_B-1:0]            mul_b_q, mul_b_d;
    logic [MUL_LAT:0]              tag_v_q, tag_v_d;
    logic [MUL_LAT:0][ID_W-1:0]    tag_id_q, tag_id_d;
    logic                          res_valid_q, res_valid_d;
    logic [WIDTH_MUL-1:0]          res_data_q, res_data_d;
    logic [ID_W-1:0]               res_id_q, res_id_d;
    logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [15:0]                   issue_cnt_q, issue_cnt_d;

    assign adv = !res_valid_q || res_ready;

    // Round-robin search starting at rr_ptr with modulo wrap.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        cand_sum  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_sum = SUM_W'(rr_ptr_q) + SUM_W'(k);
            if (cand_sum >= SUM_W'(NUM_REQ)) begin
                cand_sum = cand_sum - SUM_W'(NUM_REQ);
            end
            if (!grant_vld && req_valid[ID_W'(cand_sum)]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(cand_sum);
            end
        end
    end

    assign hs = adv && grant_vld && !rst;

    always_comb begin
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        tag_v_d     = tag_v_q;
        tag_id_d    = tag_id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        rr_ptr_d    = rr_ptr_q;
        issue_cnt_d = issue_cnt_q;
        if (adv) begin
            tag_v_d[0] = hs;
            if (hs) begin
                mul_a_d     = req_a[32'(grant_id) * WIDTH_A +: WIDTH_A];
                mul_b_d     = req_b[32'(grant_id) * WIDTH_B +: WIDTH_B];
                tag_id_d[0] = grant_id;
                rr_ptr_d    = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                issue_cnt_d = issue_cnt_q + 16'd1;
            end
            for (int unsigned k = 1; k <= MUL_LAT; k++) begin
                tag_v_d[k]  = tag_v_q[k-1];
                tag_id_d[k] = tag_id_q[k-1];
            end
            // mul_out lines up with the last tag stage.
            res_valid_d = tag_v_q[MUL_LAT];
            if (tag_v_q[MUL_LAT]) begin
                res_data_d = mul_out;
                res_id_d   = tag_id_q[MUL_LAT];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            rr_ptr_q    <= '0;
            issue_cnt_q <= '0;
        end else begin
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            rr_ptr_q    <= rr_ptr_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign req_ready  = hs ? (NUM_REQ'(1) << grant_id) : '0;
    assign mul_pip_en = adv;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_id     = res_id_q;
    assign issue_cnt  = issue_cnt_q;
    assign busy       = !rst && (res_valid_q || (|tag_v_q));

endmodule
